oc8051_ecall_ctrl: RTL and testbench
====================================

# oc8051_ecall_ctrl

Ecall sequencer for the oc8051 core. It drives the ECALL entry and return sequences. On an ECALL it snapshots the Ecall Target Register value, saves the return PC, and stalls the core until the pipeline drains. It then redirects the PC to the target and raises the privileged flag. On ERET it restores the saved PC. It sits between the instruction decoder, the ETR SFR, and the PC-load path of the core.

## Interface
Parameters:
- DRAIN_MAX, 16: cycles to wait for `core_idle` before the ECALL aborts.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ecall_req  in  1  one-cycle pulse from the decoder: ECALL decoded.
- eret_req  in  1  one-cycle pulse from the decoder: ERET decoded.
- pc_in  in  16  return address (PC of the next instruction), valid with `ecall_req`.
- etr  in  16  current ETR value.
- core_idle  in  1  core pipeline drained, with no memory access outstanding.
- fault_clr  in  1  clears the sticky fault flag.
- stall  out  1  holds the core's fetch/decode.
- pc_wr  out  1  one-cycle PC load strobe.
- pc_out  out  16  PC load value; meaningful only while `pc_wr`=1.
- priv  out  1  core is executing in ecall (privileged) context.
- etr_lock  out  1  write-blocks the ETR SFR; equals `priv` OR (state != IDLE).
- fault  out  1  sticky error flag.
- fault_code  out  2  cause of the last fault: 0 = nested ECALL, 1 = ERET outside priv, 2 = ETR zero, 3 = drain timeout.

## Operation
State machine, with the states IDLE, DRAIN, JUMP, PRIV and RET.

- IDLE
  - `ecall_req`=1 and `eret_req`=0:
    - if `etr`==0: raise fault with code 2 and stay in IDLE.
    - otherwise: capture `tgt`←`etr` and `ret`←`pc_in`, clear the drain counter, go to DRAIN.
  - `eret_req`=1 (with or without `ecall_req`): raise fault with code 1, stay in IDLE, capture nothing.
- DRAIN
  - `stall`=1.
  - If `core_idle`=1, go to JUMP.
  - Otherwise the counter increments. When the counter reaches DRAIN_MAX-1 with `core_idle` still 0, raise fault with code 3 and return to IDLE without jumping.
- JUMP
  - `stall`=1, `pc_wr`=1, `pc_out`=`tgt`. Go to PRIV.
- PRIV
  - `priv`=1 and `stall`=0.
  - `eret_req`=1: go to RET. `ecall_req` in the same cycle is ignored.
  - `ecall_req`=1 alone: raise fault with code 0 and stay in PRIV. `ret` and `tgt` are unchanged.
- RET
  - `stall`=1, `pc_wr`=1, `pc_out`=`ret`, `priv` still 1. Go to IDLE, where `priv`=0.
- Request pulses arriving in DRAIN, JUMP or RET are ignored.

Snapshot rule: `tgt` is the ETR value sampled in the `ecall_req` cycle. ETR writes after that point do not affect the jump.

Fault rules:
- "Raise fault" sets `fault`=1 and loads `fault_code`.
- Once set, `fault` stays set. A later fault overwrites `fault_code`.
- `fault_clr` clears `fault` and `fault_code` in every state. If a new fault occurs in the same cycle as `fault_clr`, the new fault wins.
- A fault never changes `priv` and never produces a `pc_wr`.

## Timing
- Reset (asynchronous): state=IDLE, `tgt`=0, `ret`=0, drain counter=0, and all outputs 0 (`stall`, `pc_wr`, `pc_out`, `priv`, `etr_lock`, `fault`, `fault_code`).
- A reset in the middle of a sequence returns to IDLE with `priv`=0 and does not issue `pc_wr`.
- All outputs are registered or decoded from state only, so there is no combinational path from the inputs.
- ECALL latency:
  - `ecall_req` at cycle N: DRAIN at N+1.
  - If `core_idle` is already 1 at N+1: JUMP (`pc_wr`) at N+2, `priv`=1 from N+3.
  - Each cycle `core_idle` stays low adds one cycle.
  - `stall` is high from N+1 through N+2 inclusive.
- ERET latency: `eret_req` at cycle M gives `pc_wr` at M+1 and `priv`=0 from M+2.
- Timeout: `stall` is high for exactly DRAIN_MAX cycles, then the block is in IDLE with `fault`=1.
- `pc_wr` is never high for two consecutive cycles.

## Test plan
- Basic ECALL: `etr`=0x1234, `pc_in`=0x0456, `ecall_req` pulse, `core_idle`=1.
  - Required: `pc_wr`=1 with `pc_out`=0x1234 two cycles later, then `priv`=1.
  - Then an `eret_req` pulse: `pc_wr`=1 with `pc_out`=0x0456 one cycle later, then `priv`=0.
- Snapshot: ECALL with `etr`=0x2000, then `etr` changes to 0x3000 during a 3-cycle drain.
  - Required: `pc_out`=0x2000, `etr_lock`=1 throughout.
- Drain timeout: `core_idle` held 0 with DRAIN_MAX=16.
  - Required: `stall` high for 16 cycles, `fault`=1, `fault_code`=3, no `pc_wr`, `priv`=0.
- Illegal requests:
  - `ecall_req` with `etr`=0: `fault_code`=2, no `stall`.
  - `eret_req` in IDLE: `fault_code`=1.
  - `ecall_req` in PRIV: `fault_code`=0 and `priv` stays 1.
  - `fault_clr` then clears `fault` to 0.
- Simultaneous requests:
  - `ecall_req` and `eret_req` together in IDLE: `fault_code`=1, no state change.
  - The same pair in PRIV: clean ERET, no fault.
- Asynchronous reset asserted in DRAIN and again in PRIV: outputs go to 0 immediately without waiting for a clock edge, and no `pc_wr` occurs.

Source files
------------

// File: rtl/oc8051_ecall_ctrl.sv
// Ecall sequencer: snapshots ETR and return PC on ECALL, drains the pipeline,
// loads the target into the PC and raises priv; ERET restores the saved PC.
module oc8051_ecall_ctrl #(
    parameter int DRAIN_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ecall_req,
    input  logic        eret_req,
    input  logic [15:0] pc_in,
    input  logic [15:0] etr,
    input  logic        core_idle,
    input  logic        fault_clr,
    output logic        stall,
    output logic        pc_wr,
    output logic [15:0] pc_out,
    output logic        priv,
    output logic        etr_lock,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int CNT_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);

    localparam logic [1:0] FC_NESTED  = 2'd0;
    localparam logic [1:0] FC_ERET    = 2'd1;
    localparam logic [1:0] FC_ETRZERO = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_JUMP  = 3'd2,
        ST_PRIV  = 3'd3,
        ST_RET   = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [15:0]      tgt_r;
    logic [15:0]      ret_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             capture_s;
    logic             fault_set_s;
    logic [1:0]       fault_code_nxt_s;
    logic             fault_r;
    logic [1:0]       fault_code_r;

    // State, snapshot and drain counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            tgt_r   <= 16'h0000;
            ret_r   <= 16'h0000;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (capture_s) begin
                tgt_r <= etr;
                ret_r <= pc_in;
            end else begin
                tgt_r <= tgt_r;
                ret_r <= ret_r;
            end
        end
    end

    // Next-state, capture and fault-detection logic
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        capture_s        = 1'b0;
        fault_set_s      = 1'b0;
        fault_code_nxt_s = FC_NESTED;
        case (state_r)
            ST_IDLE: begin
                if (eret_req) begin
                    fault_set_s      = 1'b1;
                    fault_code_nxt_s = FC_ERET;
                end else if (ecall_req) begin
                    if (etr == 16'h0000) begin
                        fault_set_s      = 1'b1;
                        fault_code_nxt_s = FC_ETRZERO;
                    end else begin
                        capture_s   = 1'b1;
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_DRAIN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (core_idle) begin
                    state_nxt_s = ST_JUMP;
                end else if (cnt_r == CNT_LAST) begin
                    // Give up: back to IDLE without touching the PC
                    fault_set_s      = 1'b1;
                    fault_code_nxt_s = FC_TIMEOUT;
                    state_nxt_s      = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_JUMP: begin
                state_nxt_s = ST_PRIV;
            end
            ST_PRIV: begin
                if (eret_req) begin
                    state_nxt_s = ST_RET;
                end else if (ecall_req) begin
                    fault_set_s      = 1'b1;
                    fault_code_nxt_s = FC_NESTED;
                end else begin
                    state_nxt_s = ST_PRIV;
                end
            end
            ST_RET: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Sticky fault flag; a new fault takes priority over a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_r      <= 1'b0;
            fault_code_r <= 2'd0;
        end else if (fault_set_s) begin
            fault_r      <= 1'b1;
            fault_code_r <= fault_code_nxt_s;
        end else if (fault_clr) begin
            fault_r      <= 1'b0;
            fault_code_r <= 2'd0;
        end else begin
            fault_r      <= fault_r;
            fault_code_r <= fault_code_r;
        end
    end

    // Outputs decoded purely from the state register
    always_comb begin
        stall    = 1'b0;
        pc_wr    = 1'b0;
        pc_out   = 16'h0000;
        priv     = 1'b0;
        etr_lock = 1'b0;
        case (state_r)
            ST_IDLE: begin
                etr_lock = 1'b0;
            end
            ST_DRAIN: begin
                stall    = 1'b1;
                etr_lock = 1'b1;
            end
            ST_JUMP: begin
                stall    = 1'b1;
                pc_wr    = 1'b1;
                pc_out   = tgt_r;
                etr_lock = 1'b1;
            end
            ST_PRIV: begin
                priv     = 1'b1;
                etr_lock = 1'b1;
            end
            ST_RET: begin
                stall    = 1'b1;
                pc_wr    = 1'b1;
                pc_out   = ret_r;
                priv     = 1'b1;
                etr_lock = 1'b1;
            end
            default: begin
                etr_lock = 1'b0;
            end
        endcase
    end

    assign fault      = fault_r;
    assign fault_code = fault_code_r;

endmodule

// File: tb/tb_oc8051_ecall_ctrl.sv
// Directed self-checking bench for oc8051_ecall_ctrl with hand-computed expectations.
module tb_oc8051_ecall_ctrl;

    logic        clk;
    logic        rst;
    logic        ecall_req;
    logic        eret_req;
    logic [15:0] pc_in;
    logic [15:0] etr;
    logic        core_idle;
    logic        fault_clr;
    logic        stall;
    logic        pc_wr;
    logic [15:0] pc_out;
    logic        priv;
    logic        etr_lock;
    logic        fault;
    logic [1:0]  fault_code;

    int n_checks = 0;
    int n_errors = 0;

    oc8051_ecall_ctrl #(.DRAIN_MAX(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .ecall_req  (ecall_req),
        .eret_req   (eret_req),
        .pc_in      (pc_in),
        .etr        (etr),
        .core_idle  (core_idle),
        .fault_clr  (fault_clr),
        .stall      (stall),
        .pc_wr      (pc_wr),
        .pc_out     (pc_out),
        .priv       (priv),
        .etr_lock   (etr_lock),
        .fault      (fault),
        .fault_code (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ECALL with core_idle=1; returns positioned in PRIV
    task automatic go_priv(input logic [15:0] t, input logic [15:0] r);
        etr = t; pc_in = r; core_idle = 1'b1; ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic clear_fault();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
    endtask

    initial begin
        int n;
        int wr_seen;
        rst = 1'b1; ecall_req = 1'b0; eret_req = 1'b0; pc_in = 16'h0;
        etr = 16'h0; core_idle = 1'b0; fault_clr = 1'b0;
        #2;
        check("rst_stall", {15'd0, stall}, 16'd0);
        check("rst_pc_wr", {15'd0, pc_wr}, 16'd0);
        check("rst_pc_out", pc_out, 16'h0000);
        check("rst_priv", {15'd0, priv}, 16'd0);
        check("rst_lock", {15'd0, etr_lock}, 16'd0);
        check("rst_fault", {14'd0, fault_code, fault}, 16'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic ECALL / ERET
        etr = 16'h1234; pc_in = 16'h0456; core_idle = 1'b1; ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
        check("ec_n1_stall", {15'd0, stall}, 16'd1);
        check("ec_n1_pc_wr", {15'd0, pc_wr}, 16'd0);
        check("ec_n1_lock", {15'd0, etr_lock}, 16'd1);
        tick();
        check("ec_n2_pc_wr", {15'd0, pc_wr}, 16'd1);
        check("ec_n2_pc_out", pc_out, 16'h1234);
        check("ec_n2_stall", {15'd0, stall}, 16'd1);
        check("ec_n2_priv", {15'd0, priv}, 16'd0);
        tick();
        check("ec_n3_priv", {15'd0, priv}, 16'd1);
        check("ec_n3_stall", {15'd0, stall}, 16'd0);
        check("ec_n3_pc_wr", {15'd0, pc_wr}, 16'd0);
        eret_req = 1'b1;
        tick();
        eret_req = 1'b0;
        check("er_m1_pc_wr", {15'd0, pc_wr}, 16'd1);
        check("er_m1_pc_out", pc_out, 16'h0456);
        check("er_m1_priv", {15'd0, priv}, 16'd1);
        tick();
        check("er_m2_priv", {15'd0, priv}, 16'd0);
        check("er_m2_pc_wr", {15'd0, pc_wr}, 16'd0);
        check("er_m2_lock", {15'd0, etr_lock}, 16'd0);
        check("er_m2_fault", {15'd0, fault}, 16'd0);

        // Snapshot: ETR changes during a 3-cycle drain
        etr = 16'h2000; pc_in = 16'h0100; core_idle = 1'b0; ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
        etr = 16'h3000;
        for (int i = 0; i < 3; i++) begin
            check("snap_stall", {15'd0, stall}, 16'd1);
            check("snap_lock", {15'd0, etr_lock}, 16'd1);
            check("snap_pc_wr", {15'd0, pc_wr}, 16'd0);
            tick();
        end
        core_idle = 1'b1;
        check("snap_lock_d", {15'd0, etr_lock}, 16'd1);
        tick();
        check("snap_pc_wr_j", {15'd0, pc_wr}, 16'd1);
        check("snap_pc_out", pc_out, 16'h2000);
        check("snap_lock_j", {15'd0, etr_lock}, 16'd1);
        tick();
        check("snap_lock_p", {15'd0, etr_lock}, 16'd1);
        eret_req = 1'b1;
        tick();
        eret_req = 1'b0;
        check("snap_ret_pc", pc_out, 16'h0100);
        tick();

        // Drain timeout
        etr = 16'h1111; pc_in = 16'h0200; core_idle = 1'b0; ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
        n = 0; wr_seen = 0;
        while (stall && n < 40) begin
            n++;
            if (pc_wr) wr_seen++;
            tick();
        end
        check("to_stall_cycles", 16'(n), 16'd16);
        check("to_pc_wr_seen", 16'(wr_seen), 16'd0);
        check("to_fault", {15'd0, fault}, 16'd1);
        check("to_code", {14'd0, fault_code}, 16'd3);
        check("to_priv", {15'd0, priv}, 16'd0);
        check("to_lock", {15'd0, etr_lock}, 16'd0);
        clear_fault();
        check("clr_fault", {15'd0, fault}, 16'd0);
        check("clr_code", {14'd0, fault_code}, 16'd0);

        // ECALL with ETR zero
        etr = 16'h0000; core_idle = 1'b1; ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
        check("ez_fault", {15'd0, fault}, 16'd1);
        check("ez_code", {14'd0, fault_code}, 16'd2);
        check("ez_stall", {15'd0, stall}, 16'd0);
        check("ez_lock", {15'd0, etr_lock}, 16'd0);
        // New fault in same cycle as clear wins
        eret_req = 1'b1; fault_clr = 1'b1;
        tick();
        eret_req = 1'b0; fault_clr = 1'b0;
        check("ei_fault", {15'd0, fault}, 16'd1);
        check("ei_code", {14'd0, fault_code}, 16'd1);
        check("ei_stall", {15'd0, stall}, 16'd0);
        clear_fault();
        check("ei_clr", {15'd0, fault}, 16'd0);

        // Nested ECALL in PRIV
        go_priv(16'h4000, 16'h0333);
        check("np_priv0", {15'd0, priv}, 16'd1);
        etr = 16'h5000; pc_in = 16'h0777; ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
        check("np_fault", {15'd0, fault}, 16'd1);
        check("np_code", {14'd0, fault_code}, 16'd0);
        check("np_priv", {15'd0, priv}, 16'd1);
        check("np_pc_wr", {15'd0, pc_wr}, 16'd0);
        clear_fault();
        check("np_clr", {15'd0, fault}, 16'd0);
        eret_req = 1'b1;
        tick();
        eret_req = 1'b0;
        check("np_ret_pc", pc_out, 16'h0333);
        tick();

        // Simultaneous requests in IDLE
        etr = 16'h1234; ecall_req = 1'b1; eret_req = 1'b1;
        tick();
        ecall_req = 1'b0; eret_req = 1'b0;
        check("si_code", {14'd0, fault_code}, 16'd1);
        check("si_fault", {15'd0, fault}, 16'd1);
        check("si_stall", {15'd0, stall}, 16'd0);
        check("si_lock", {15'd0, etr_lock}, 16'd0);
        clear_fault();

        // Simultaneous requests in PRIV: clean ERET
        go_priv(16'h6000, 16'h0888);
        ecall_req = 1'b1; eret_req = 1'b1;
        tick();
        ecall_req = 1'b0; eret_req = 1'b0;
        check("sp_pc_wr", {15'd0, pc_wr}, 16'd1);
        check("sp_pc_out", pc_out, 16'h0888);
        check("sp_fault", {15'd0, fault}, 16'd0);
        tick();
        check("sp_priv", {15'd0, priv}, 16'd0);
        check("sp_pc_wr2", {15'd0, pc_wr}, 16'd0);

        // Async reset in DRAIN
        etr = 16'h7000; core_idle = 1'b0; ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
        check("ra_pre_stall", {15'd0, stall}, 16'd1);
        #2 rst = 1'b1;
        #1;
        check("ra_stall", {15'd0, stall}, 16'd0);
        check("ra_lock", {15'd0, etr_lock}, 16'd0);
        check("ra_pc_wr", {15'd0, pc_wr}, 16'd0);
        core_idle = 1'b1;
        tick();
        rst = 1'b0;
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (pc_wr) wr_seen++;
            tick();
        end
        check("ra_no_pc_wr", 16'(wr_seen), 16'd0);

        // Async reset in PRIV
        go_priv(16'h7100, 16'h0999);
        check("rp_pre_priv", {15'd0, priv}, 16'd1);
        #2 rst = 1'b1;
        #1;
        check("rp_priv", {15'd0, priv}, 16'd0);
        check("rp_lock", {15'd0, etr_lock}, 16'd0);
        check("rp_pc_wr", {15'd0, pc_wr}, 16'd0);
        tick();
        rst = 1'b0;
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (pc_wr) wr_seen++;
            tick();
        end
        check("rp_no_pc_wr", 16'(wr_seen), 16'd0);
        check("rp_priv_after", {15'd0, priv}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
